ad9361_spi_slave: RTL and testbench



---
 rtl/ad9361_spi_slave.sv | 177 +++++++++++++++++
 tb/tb_ad9361_spi_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_spi_slave.sv
// AD9361 register-port responder: decodes 4-wire SPI instruction frames against a
// 1024x8 register file, with a read-only product ID and a self-clearing cal register.
module ad9361_spi_slave #(
    parameter logic [7:0] PRODUCT_ID = 8'h0A,
    parameter int         CAL_CYCLES = 2000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       ad9361_spi_cs,
    input  logic       ad9361_spi_sclk,
    input  logic       ad9361_spi_mosi,
    output logic       ad9361_spi_miso,
    output logic       reg_wr_en,
    output logic [9:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       frame_err
);

    localparam logic [9:0] ADDR_PID = 10'h037;
    localparam logic [9:0] ADDR_CAL = 10'h016;
    localparam int         CAL_W    = $clog2(CAL_CYCLES + 1);

    typedef enum logic [2:0] {WAIT_CS, IDLE, INSTR, DATA, DONE} state_t;

    state_t           state;
    logic             cs_p0, cs_p1, cs_p2;
    logic             sclk_p0, sclk_p1, sclk_p2;
    logic             mosi_p0, mosi_p1;
    logic             cs_rise, sclk_rise, sclk_fall;
    logic [14:0]      shift_reg;
    logic [7:0]       shift_byte;
    logic [3:0]       bit_cnt;
    logic [2:0]       byte_cnt;
    logic             wr_rdn;
    logic [9:0]       addr;
    logic [7:0]       rd_byte;
    logic             cal_busy;
    logic [CAL_W-1:0] cal_cnt;
    logic [7:0]       regfile [1024];

    function automatic logic [7:0] reg_read(input logic [9:0] a);
        return (a == ADDR_PID) ? PRODUCT_ID : regfile[a];
    endfunction

    // Stage p0/p1: two-flop synchronizers; p2 is the edge-detect delay.
    // cs resets low so that WAIT_CS only releases on a genuinely high cs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
        end else begin
            cs_p0   <= ad9361_spi_cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            sclk_p0 <= ad9361_spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
        end
    end

    always_ff @(posedge sys_clk) begin
        mosi_p0 <= ad9361_spi_mosi;
        mosi_p1 <= mosi_p0;
    end

    assign cs_rise    = cs_p1 & ~cs_p2;
    assign sclk_rise  = sclk_p1 & ~sclk_p2;
    assign sclk_fall  = ~sclk_p1 & sclk_p2;
    assign shift_byte = {shift_reg[6:0], mosi_p1};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state           <= WAIT_CS;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            wr_rdn          <= 1'b0;
            addr            <= '0;
            ad9361_spi_miso <= 1'b0;
            reg_wr_en       <= 1'b0;
            reg_wr_addr     <= '0;
            reg_wr_data     <= '0;
            frame_err       <= 1'b0;
            cal_busy        <= 1'b0;
            cal_cnt         <= '0;
            for (int i = 0; i < 1024; i++) regfile[i] <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            frame_err <= 1'b0;

            // A fresh write to the cal register later in this block overrides the clear.
            if (cal_busy) begin
                cal_cnt <= cal_cnt - CAL_W'(1);
                if (cal_cnt == CAL_W'(1)) begin
                    cal_busy          <= 1'b0;
                    regfile[ADDR_CAL] <= '0;
                end
            end

            case (state)
                WAIT_CS: begin
                    ad9361_spi_miso <= 1'b0;
                    if (cs_p1) state <= IDLE;
                end
                IDLE: begin
                    ad9361_spi_miso <= 1'b0;
                    bit_cnt         <= '0;
                    if (!cs_p1) state <= INSTR;
                end
                INSTR: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[13:0], mosi_p1};
                        if (bit_cnt == 4'd15) begin
                            wr_rdn   <= shift_reg[14];
                            byte_cnt <= shift_reg[13:11];
                            addr     <= {shift_reg[8:0], mosi_p1};
                            rd_byte  <= reg_read({shift_reg[8:0], mosi_p1});
                            bit_cnt  <= '0;
                            state    <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        frame_err       <= 1'b1;
                        ad9361_spi_miso <= 1'b0;
                        state           <= IDLE;
                    end else if (sclk_fall) begin
                        if (!wr_rdn) begin
                            ad9361_spi_miso <= rd_byte[7];
                            rd_byte         <= {rd_byte[6:0], 1'b0};
                        end
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[13:0], mosi_p1};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr - 10'd1;
                            rd_byte <= reg_read(addr - 10'd1);
                            if (wr_rdn) begin
                                reg_wr_en     <= 1'b1;
                                reg_wr_addr   <= addr;
                                reg_wr_data   <= shift_byte;
                                regfile[addr] <= shift_byte;
                                if (addr == ADDR_CAL) begin
                                    cal_busy <= 1'b1;
                                    cal_cnt  <= CAL_W'(CAL_CYCLES);
                                end
                            end
                            if (byte_cnt == 3'd0) begin
                                ad9361_spi_miso <= 1'b0;
                                state           <= DONE;
                            end else begin
                                byte_cnt <= byte_cnt - 3'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    ad9361_spi_miso <= 1'b0;
                    if (cs_p1) state <= IDLE;
                end
                default: state <= WAIT_CS;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9361_spi_slave.sv
// Bench for ad9361_spi_slave: SPI master model, table of access vectors,
// write-strobe scoreboard and hand-written cal/abort/reset sequences.
module tb_ad9361_spi_slave;

    localparam int CAL_CYCLES = 2000;
    localparam int HALF       = 4;
    localparam int GAP        = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       cs, sclk, mosi;
    logic       miso;
    logic       reg_wr_en;
    logic [9:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ferr_exp = 0;
    logic [17:0] wq [$];

    typedef struct {
        logic             wr;
        logic [9:0]       addr;
        int               n;
        logic [0:7][7:0]  bytes;
    } vec_t;

    vec_t tbl [14];

    ad9361_spi_slave #(.PRODUCT_ID(8'h0A), .CAL_CYCLES(CAL_CYCLES)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .ad9361_spi_cs(cs), .ad9361_spi_sclk(sclk), .ad9361_spi_mosi(mosi),
        .ad9361_spi_miso(miso), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (reg_wr_en) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_strobe actual %0h/%0h required none", reg_wr_addr, reg_wr_data);
            end else begin
                check("wr_strobe", {14'd0, reg_wr_addr, reg_wr_data}, {14'd0, wq.pop_front()});
            end
        end
        if (frame_err) ferr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic wr, input logic [9:0] a, input int n,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        vec_t v;
        v.wr = wr; v.addr = a; v.n = n;
        v.bytes = {b0, b1, b2, 40'd0};
        return v;
    endfunction

    task automatic sclk_bit(input logic m, output logic s);
        mosi = m;
        repeat (HALF) @(negedge sys_clk);
        sclk = 1'b1;
        s = miso;
        repeat (HALF) @(negedge sys_clk);
        sclk = 1'b0;
    endtask

    // Drives up to max_bits SCLKs of a frame; queues a strobe only for whole write bytes.
    task automatic spi_frame(input logic wr, input logic [9:0] a, input int n,
                             input logic [0:7][7:0] wd, input int max_bits,
                             output logic [0:7][7:0] rd);
        logic [15:0] instr;
        logic [9:0]  a_cur;
        logic        s;
        int          bits;
        instr = {wr, 3'(n - 1), 2'b00, a};
        a_cur = a;
        rd    = '0;
        bits  = 0;
        @(negedge sys_clk);
        cs = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        for (int i = 0; i < 16; i++) begin
            if (bits < max_bits) begin
                sclk_bit(instr[15-i], s);
                bits++;
            end
        end
        for (int b = 0; b < n; b++) begin
            if (wr && bits + 8 <= max_bits) wq.push_back({a_cur, wd[b]});
            for (int k = 0; k < 8; k++) begin
                if (bits < max_bits) begin
                    sclk_bit(wr ? wd[b][7-k] : 1'b0, s);
                    rd[b][7-k] = s;
                    bits++;
                end
            end
            a_cur = a_cur - 10'd1;
        end
        mosi = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        cs = 1'b1;
        repeat (GAP) @(negedge sys_clk);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        logic [0:7][7:0] rd;
        spi_frame(1'b1, a, 1, {d, 56'd0}, 64, rd);
    endtask

    task automatic do_read(input string nm, input logic [9:0] a, input logic [7:0] exp);
        logic [0:7][7:0] rd;
        spi_frame(1'b0, a, 1, '0, 64, rd);
        check(nm, {24'd0, rd[0]}, {24'd0, exp});
    endtask

    initial begin
        logic [0:7][7:0] rd;
        logic            s;
        logic [15:0]     instr;

        tbl[0]  = mk(1'b1, 10'h3DF, 1, 8'h01, 8'h00, 8'h00);
        tbl[1]  = mk(1'b0, 10'h3DF, 1, 8'h01, 8'h00, 8'h00);
        tbl[2]  = mk(1'b0, 10'h037, 1, 8'h0A, 8'h00, 8'h00);
        tbl[3]  = mk(1'b1, 10'h037, 1, 8'hFF, 8'h00, 8'h00);
        tbl[4]  = mk(1'b0, 10'h037, 1, 8'h0A, 8'h00, 8'h00);
        tbl[5]  = mk(1'b1, 10'h102, 3, 8'h11, 8'h22, 8'h33);
        tbl[6]  = mk(1'b1, 10'h3FF, 1, 8'h5A, 8'h00, 8'h00);
        tbl[7]  = mk(1'b0, 10'h000, 2, 8'h00, 8'h5A, 8'h00);
        tbl[8]  = mk(1'b0, 10'h102, 3, 8'h11, 8'h22, 8'h33);
        tbl[9]  = mk(1'b1, 10'h05E, 1, 8'hC3, 8'h00, 8'h00);
        tbl[10] = mk(1'b0, 10'h05E, 1, 8'hC3, 8'h00, 8'h00);
        tbl[11] = mk(1'b1, 10'h247, 1, 8'h02, 8'h00, 8'h00);
        tbl[12] = mk(1'b0, 10'h247, 1, 8'h02, 8'h00, 8'h00);
        tbl[13] = mk(1'b1, 10'h2A0, 1, 8'h77, 8'h00, 8'h00);

        cs = 1'b1; sclk = 1'b0; mosi = 1'b0; sys_rst = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("rst_wr_addr", {22'd0, reg_wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, reg_wr_data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);

        for (int v = 0; v < 14; v++) begin
            spi_frame(tbl[v].wr, tbl[v].addr, tbl[v].n, tbl[v].bytes, 128, rd);
            if (!tbl[v].wr)
                for (int b = 0; b < tbl[v].n; b++)
                    check($sformatf("vec%0d_rd%0d", v, b), {24'd0, rd[b]}, {24'd0, tbl[v].bytes[b]});
        end
        check("vec_no_ferr", ferr_cnt, ferr_exp);

        // Cal register self-clear, then restart by a second write.
        do_write(10'h016, 8'h80);
        do_read("cal_now", 10'h016, 8'h80);
        repeat (CAL_CYCLES + 10) @(negedge sys_clk);
        do_read("cal_cleared", 10'h016, 8'h00);
        do_write(10'h016, 8'h80);
        repeat (CAL_CYCLES / 2) @(negedge sys_clk);
        do_write(10'h016, 8'h40);
        repeat (CAL_CYCLES - 400) @(negedge sys_clk);
        do_read("cal_restart_hold", 10'h016, 8'h40);
        repeat (400) @(negedge sys_clk);
        do_read("cal_restart_clear", 10'h016, 8'h00);

        // Aborts: partial data byte, inside instruction, truncated at byte boundary.
        spi_frame(1'b1, 10'h2A0, 1, {8'h99, 56'd0}, 20, rd);
        ferr_exp++;
        check("abort_data_ferr", ferr_cnt, ferr_exp);
        do_read("abort_data_keep", 10'h2A0, 8'h77);
        spi_frame(1'b1, 10'h2A0, 1, {8'h99, 56'd0}, 10, rd);
        ferr_exp++;
        check("abort_instr_ferr", ferr_cnt, ferr_exp);
        spi_frame(1'b1, 10'h2C0, 2, {8'hAB, 8'hCD, 48'd0}, 24, rd);
        ferr_exp++;
        check("trunc_ferr", ferr_cnt, ferr_exp);
        do_read("trunc_first", 10'h2C0, 8'hAB);
        do_read("trunc_second", 10'h2BF, 8'h00);

        // Reset mid-frame with cs held low; remaining SCLKs must be ignored.
        instr = 16'h82B0;
        @(negedge sys_clk);
        cs = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        for (int i = 0; i < 16; i++) sclk_bit(instr[15-i], s);
        for (int i = 0; i < 4; i++) sclk_bit(1'b1, s);
        sys_rst = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("midrst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        sys_rst = 1'b0;
        for (int i = 0; i < 12; i++) sclk_bit(1'b1, s);
        repeat (HALF) @(negedge sys_clk);
        cs = 1'b1;
        repeat (GAP) @(negedge sys_clk);
        check("midrst_no_ferr", ferr_cnt, ferr_exp);
        check("midrst_no_write", wq.size(), 0);
        do_read("midrst_cleared", 10'h3DF, 8'h00);
        do_write(10'h2B0, 8'hEE);
        do_read("midrst_next_frame", 10'h2B0, 8'hEE);

        check("scoreboard_drained", wq.size(), 0);
        check("final_ferr", ferr_cnt, ferr_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
